// File: rtl/tx_frame_packetizer_if.sv
// Bus bundle for the TX frame packetizer: frame request, RAM read port,
// UART TX FIFO write port and frame status.
interface tx_frame_packetizer_if #(
    parameter int ADDR_W = 13
);
    logic              frame_tick;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              fifo_full;
    logic              push;
    logic [7:0]        push_data;
    logic              busy;
    logic              frame_done;

    // Packetizer side
    modport master (
        input  frame_tick,
        input  ram_rdata,
        input  fifo_full,
        output ram_re,
        output ram_addr,
        output push,
        output push_data,
        output busy,
        output frame_done
    );

    // Environment side (RAM, FIFO, frame scheduler)
    modport slave (
        output frame_tick,
        output ram_rdata,
        output fifo_full,
        input  ram_re,
        input  ram_addr,
        input  push,
        input  push_data,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/tx_frame_packetizer.sv
// TX frame packetizer: on frame_tick, streams one packet into the UART TX
// FIFO: SYNC0, SYNC1, 16-bit big-endian length, payload bytes read from RAM
// addresses 0..PAYLOAD_BYTES-1, then the XOR of the payload bytes.
// Every output is registered; a push is decided from fifo_full in the cycle
// before the push becomes visible, so a stall never drops or repeats a byte.
module tx_frame_packetizer #(
    parameter int         PAYLOAD_BYTES = 4800,
    parameter int         ADDR_W        = 13,
    parameter logic [7:0] SYNC0         = 8'hAA,
    parameter logic [7:0] SYNC1         = 8'h55
) (
    input  logic                   clk,
    input  logic                   reset,
    tx_frame_packetizer_if.master  bus
);

    localparam logic [15:0]       LEN_VAL   = 16'(PAYLOAD_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HDR0    = 4'd1,
        HDR1    = 4'd2,
        LEN_H   = 4'd3,
        LEN_L   = 4'd4,
        RD_REQ  = 4'd5,
        RD_WAIT = 4'd6,
        PAY     = 4'd7,
        CKSUM   = 4'd8,
        DONE    = 4'd9
    } state_t;

    // Running checksum update: the packet check byte is a plain XOR fold.
    function automatic logic [7:0] cksum_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t            state_r,      state_s;
    logic              ram_re_r,     ram_re_s;
    logic [ADDR_W-1:0] ram_addr_r,   ram_addr_s;
    logic [7:0]        hold_r,       hold_s;
    logic [7:0]        cksum_r,      cksum_s;
    logic              push_r,       push_s;
    logic [7:0]        push_data_r,  push_data_s;
    logic              busy_r,       busy_s;
    logic              frame_done_r, frame_done_s;

    // Next-state and next-output decode; ram_re/ram_addr are set on entry to
    // RD_REQ so the RAM sees them during RD_REQ and answers during RD_WAIT.
    always_comb begin
        state_s      = state_r;
        ram_re_s     = 1'b0;
        ram_addr_s   = ram_addr_r;
        hold_s       = hold_r;
        cksum_s      = cksum_r;
        push_s       = 1'b0;
        push_data_s  = 8'h00;
        busy_s       = busy_r;
        frame_done_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.frame_tick) begin
                    state_s    = HDR0;
                    cksum_s    = 8'h00;
                    ram_addr_s = {ADDR_W{1'b0}};
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            HDR0: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = SYNC0;
                    state_s     = HDR1;
                end else begin
                    state_s     = HDR0;
                end
            end
            HDR1: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = SYNC1;
                    state_s     = LEN_H;
                end else begin
                    state_s     = HDR1;
                end
            end
            LEN_H: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = LEN_VAL[15:8];
                    state_s     = LEN_L;
                end else begin
                    state_s     = LEN_H;
                end
            end
            LEN_L: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = LEN_VAL[7:0];
                    ram_re_s    = 1'b1;
                    state_s     = RD_REQ;
                end else begin
                    state_s     = LEN_L;
                end
            end
            RD_REQ: begin
                state_s = RD_WAIT;
            end
            RD_WAIT: begin
                hold_s  = bus.ram_rdata;
                state_s = PAY;
            end
            PAY: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = hold_r;
                    cksum_s     = cksum_fold(cksum_r, hold_r);
                    if (ram_addr_r == LAST_ADDR) begin
                        state_s = CKSUM;
                    end else begin
                        ram_addr_s = ram_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ram_re_s   = 1'b1;
                        state_s    = RD_REQ;
                    end
                end else begin
                    state_s = PAY;
                end
            end
            CKSUM: begin
                if (!bus.fifo_full) begin
                    push_s      = 1'b1;
                    push_data_s = cksum_r;
                    state_s     = DONE;
                end else begin
                    state_s     = CKSUM;
                end
            end
            DONE: begin
                frame_done_s = 1'b1;
                busy_s       = 1'b0;
                ram_addr_s   = {ADDR_W{1'b0}};
                state_s      = IDLE;
            end
            default: begin
                busy_s     = 1'b0;
                ram_addr_s = {ADDR_W{1'b0}};
                state_s    = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ram_re_r     <= 1'b0;
            ram_addr_r   <= {ADDR_W{1'b0}};
            hold_r       <= 8'h00;
            cksum_r      <= 8'h00;
            push_r       <= 1'b0;
            push_data_r  <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            ram_re_r     <= ram_re_s;
            ram_addr_r   <= ram_addr_s;
            hold_r       <= hold_s;
            cksum_r      <= cksum_s;
            push_r       <= push_s;
            push_data_r  <= push_data_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign bus.ram_re     = ram_re_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.push       = push_r;
    assign bus.push_data  = push_data_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_tx_frame_packetizer.sv
// Bench for tx_frame_packetizer: a 4-byte-payload instance for table rows,
// corner sequences and random stalls, plus a 4800-byte instance for the
// full-size frame. Expected packets come from a queue-based packet model.
module tb_tx_frame_packetizer;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  exp_ck;
        logic [7:0]  stall_pct;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        tick   [2];
    logic        full   [2];
    logic [7:0]  rdata  [2];
    logic        push_w [2];
    logic [7:0]  data_w [2];
    logic        re_w   [2];
    logic [12:0] addr_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [7:0]  mem    [2][8192];

    bq_t pq0, pq1;
    int  done_cnt  [2];
    int  last_addr [2];
    int  max_addr  [2];
    logic full_prev [2];

    int errors = 0;
    int checks = 0;
    int frame_start;
    int done_base;

    tx_frame_packetizer_if #(.ADDR_W(13)) bus_a ();
    tx_frame_packetizer_if #(.ADDR_W(13)) bus_b ();

    tx_frame_packetizer #(.PAYLOAD_BYTES(4), .ADDR_W(13), .SYNC0(8'hAA), .SYNC1(8'h55)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    tx_frame_packetizer #(.PAYLOAD_BYTES(4800), .ADDR_W(13), .SYNC0(8'hAA), .SYNC1(8'h55)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.frame_tick = tick[0];
    assign bus_a.fifo_full  = full[0];
    assign bus_a.ram_rdata  = rdata[0];
    assign bus_b.frame_tick = tick[1];
    assign bus_b.fifo_full  = full[1];
    assign bus_b.ram_rdata  = rdata[1];

    assign push_w[0] = bus_a.push;       assign push_w[1] = bus_b.push;
    assign data_w[0] = bus_a.push_data;  assign data_w[1] = bus_b.push_data;
    assign re_w[0]   = bus_a.ram_re;     assign re_w[1]   = bus_b.ram_re;
    assign addr_w[0] = bus_a.ram_addr;   assign addr_w[1] = bus_b.ram_addr;
    assign busy_w[0] = bus_a.busy;       assign busy_w[1] = bus_b.busy;
    assign done_w[0] = bus_a.frame_done; assign done_w[1] = bus_b.frame_done;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Synchronous-read RAM model: data one cycle after ram_re.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (re_w[i]) rdata[i] <= mem[i][addr_w[i]];
        end
    end

    // Output monitor: collects pushed bytes, frame_done pulses, read addresses,
    // and checks that no push follows a cycle with fifo_full high.
    initial begin
        for (int i = 0; i < 2; i++) begin
            done_cnt[i]  = 0;
            last_addr[i] = -1;
            max_addr[i]  = -1;
            full_prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (push_w[i] === 1'b1) begin
                    check_eq($sformatf("push_after_full_%0d", i), longint'(full_prev[i]), 64'd0);
                    if (i == 0) pq0.push_back(data_w[i]);
                    else        pq1.push_back(data_w[i]);
                end
                if (done_w[i] === 1'b1) done_cnt[i]++;
                if (re_w[i] === 1'b1) begin
                    last_addr[i] = int'(addr_w[i]);
                    if (last_addr[i] > max_addr[i]) max_addr[i] = last_addr[i];
                end
                full_prev[i] = full[i];
            end
        end
    end

    function automatic int qsize(input int sel);
        return (sel == 0) ? pq0.size() : pq1.size();
    endfunction

    task automatic get_q(input int sel, input int start, output bq_t q);
        q = {};
        for (int i = start; i < qsize(sel); i++) begin
            if (sel == 0) q.push_back(pq0[i]);
            else          q.push_back(pq1[i]);
        end
    endtask

    // Reference packet: sync, big-endian length, payload, XOR of payload.
    task automatic model_packet(input int sel, input int n, output bq_t q);
        logic [7:0] ck;
        q  = {};
        ck = 8'h00;
        q.push_back(8'hAA);
        q.push_back(8'h55);
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            q.push_back(mem[sel][i]);
            ck = ck ^ mem[sel][i];
        end
        q.push_back(ck);
    endtask

    task automatic compare_packet(input int sel, input int n, input string name);
        bq_t exp_q, got_q;
        int  mis;
        model_packet(sel, n, exp_q);
        get_q(sel, frame_start, got_q);
        check_eq({name, "_len"}, longint'(got_q.size()), longint'(exp_q.size()));
        mis = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i] && mis < 0) mis = i;
        end
        check_eq({name, "_first_bad_idx"}, longint'(mis), -64'sd1);
    endtask

    // Requests one frame and runs cycle by cycle until frame_done, an abort
    // point (reset raised after abort_after pushes) or the cycle budget.
    task automatic run_frame(input int sel, input int n, input int stall_pct,
                             input int retick_at, input int abort_after, output int cycles);
        int stall_left;
        int pcnt;
        bit fin;
        frame_start = qsize(sel);
        done_base   = done_cnt[sel];
        stall_left  = 0;
        pcnt        = 0;
        cycles      = 0;
        fin         = 1'b0;
        @(posedge clk); #1;
        tick[sel] = 1'b1;
        full[sel] = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            cycles++;
            tick[sel] = (cycles == retick_at);
            if (stall_left > 0) begin
                full[sel] = 1'b1;
                stall_left--;
            end else if (int'($urandom_range(0, 99)) < stall_pct) begin
                full[sel] = 1'b1;
                stall_left = 4;
            end else begin
                full[sel] = 1'b0;
            end
            @(negedge clk);
            if (push_w[sel] === 1'b1) pcnt++;
            if (cycles == 1) check_eq("busy_after_tick", longint'(busy_w[sel]), 64'd1);
            if (abort_after > 0 && pcnt == abort_after) begin
                reset = 1'b1;
                fin   = 1'b1;
            end else if (done_w[sel] === 1'b1) begin
                fin = 1'b1;
            end else if (cycles > 10 * n + 200) begin
                check_eq("frame_timeout_cycles", longint'(cycles), longint'(10 * n + 200));
                fin = 1'b1;
            end
        end
        tick[sel] = 1'b0;
        full[sel] = 1'b0;
    endtask

    task automatic idle_check(input int sel, input int k, input int exp_done);
        int s0;
        s0 = qsize(sel);
        repeat (k) @(negedge clk);
        check_eq("no_extra_push", longint'(qsize(sel)), longint'(s0));
        check_eq("busy_idle", longint'(busy_w[sel]), 64'd0);
        check_eq("frame_done_count", longint'(done_cnt[sel] - done_base), longint'(exp_done));
    endtask

    task automatic check_outputs_zero(input int sel, input string name);
        check_eq({name, "_push"},       longint'(push_w[sel]), 64'd0);
        check_eq({name, "_push_data"},  longint'(data_w[sel]), 64'd0);
        check_eq({name, "_ram_re"},     longint'(re_w[sel]),   64'd0);
        check_eq({name, "_ram_addr"},   longint'(addr_w[sel]), 64'd0);
        check_eq({name, "_busy"},       longint'(busy_w[sel]), 64'd0);
        check_eq({name, "_frame_done"}, longint'(done_w[sel]), 64'd0);
    endtask

    task automatic load_small(input logic [31:0] d);
        mem[0][0] = d[31:24];
        mem[0][1] = d[23:16];
        mem[0][2] = d[15:8];
        mem[0][3] = d[7:0];
    endtask

    vec_t tbl [5];

    initial begin
        int   cyc;
        bq_t  got_q;
        logic [31:0] rnd;

        tbl[0] = '{data: 32'h01020408, exp_ck: 8'h0F, stall_pct: 8'd0};
        tbl[1] = '{data: 32'h01020408, exp_ck: 8'h0F, stall_pct: 8'd15};
        tbl[2] = '{data: 32'h12345678, exp_ck: 8'h08, stall_pct: 8'd0};
        tbl[3] = '{data: 32'h80011008, exp_ck: 8'h99, stall_pct: 8'd20};
        tbl[4] = '{data: 32'hFF00FF00, exp_ck: 8'h00, stall_pct: 8'd25};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick[i] = 1'b0;
            full[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "reset_a");
        check_outputs_zero(1, "reset_b");
        @(posedge clk); #1;
        reset = 1'b0;

        // Table rows: fixed payloads, expected checksum and stall density.
        for (int r = 0; r < 5; r++) begin
            load_small(tbl[r].data);
            run_frame(0, 4, int'(tbl[r].stall_pct), -1, 0, cyc);
            compare_packet(0, 4, $sformatf("row%0d", r));
            get_q(0, frame_start, got_q);
            if (got_q.size() == 9)
                check_eq($sformatf("row%0d_cksum", r), longint'(got_q[8]), longint'(tbl[r].exp_ck));
            if (tbl[r].stall_pct == 8'd0)
                check_eq($sformatf("row%0d_latency", r), longint'(cyc - 1), longint'(4 + 3 * 4 + 2));
            idle_check(0, 5, 1);
        end

        // frame_tick re-pulsed during the payload phase: still one packet.
        load_small(32'h01020408);
        run_frame(0, 4, 0, 10, 0, cyc);
        compare_packet(0, 4, "retick_payload");
        idle_check(0, 30, 1);

        // frame_tick in the DONE cycle is dropped.
        run_frame(0, 4, 0, 18, 0, cyc);
        compare_packet(0, 4, "retick_done");
        idle_check(0, 30, 1);

        // A fresh frame_tick after frame_done gives a second identical packet.
        run_frame(0, 4, 0, -1, 0, cyc);
        compare_packet(0, 4, "second_packet");
        idle_check(0, 5, 1);

        // Reset after the 6th push aborts the packet.
        run_frame(0, 4, 0, -1, 6, cyc);
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "abort");
        get_q(0, frame_start, got_q);
        check_eq("abort_push_count", longint'(got_q.size()), 64'd6);
        if (got_q.size() >= 6)
            check_eq("abort_6th_byte", longint'(got_q[5]), 64'h02);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_check(0, 10, 0);
        run_frame(0, 4, 0, -1, 0, cyc);
        compare_packet(0, 4, "after_abort");
        get_q(0, frame_start, got_q);
        if (got_q.size() > 0)
            check_eq("after_abort_first", longint'(got_q[0]), 64'hAA);
        idle_check(0, 5, 1);

        // Random payloads and random stall windows against the model.
        for (int k = 0; k < 6; k++) begin
            rnd = $urandom;
            load_small(rnd);
            run_frame(0, 4, int'($urandom_range(0, 40)), -1, 0, cyc);
            compare_packet(0, 4, $sformatf("rand%0d", k));
            idle_check(0, 5, 1);
        end

        // Full-size frame: RAM[i] = i[7:0].
        for (int i = 0; i < 4800; i++) mem[1][i] = 8'(i);
        run_frame(1, 4800, 5, -1, 0, cyc);
        compare_packet(1, 4800, "big");
        get_q(1, frame_start, got_q);
        check_eq("big_push_count", longint'(got_q.size()), 64'd4805);
        if (got_q.size() == 4805) begin
            check_eq("big_len_hi", longint'(got_q[2]), 64'h12);
            check_eq("big_len_lo", longint'(got_q[3]), 64'hC0);
            check_eq("big_cksum",  longint'(got_q[4804]), 64'h00);
        end
        check_eq("big_last_addr", longint'(last_addr[1]), 64'd4799);
        check_eq("big_max_addr",  longint'(max_addr[1]),  64'd4799);
        idle_check(1, 5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_packetizer.md
Name: tx_frame_packetizer

Overview:
- Sits between the TX frame RAM and the UART TX FIFO in the pen-plotter edge-image uplink.
- On a frame start pulse, emits one packet into the FIFO, one byte per push: 2 sync bytes, a 16-bit big-endian payload length, the payload bytes read from RAM at address 0..N-1, then an XOR checksum byte.
- Byte pushes obey FIFO-full backpressure.
- Gives the host PC a self-delimiting, checkable frame stream.

Parameters:
- PAYLOAD_BYTES, 4800, payload bytes per frame (packed 1-bit edge pixels); range 1..65535.
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= PAYLOAD_BYTES.
- SYNC0, 8'hAA, first sync byte.
- SYNC1, 8'h55, second sync byte.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse; requests one packet
- ram_re  output  1  RAM read enable; data returns on ram_rdata the next cycle
- ram_addr  output  ADDR_W  RAM read address
- ram_rdata  input  8  RAM read data, valid 1 cycle after ram_re
- fifo_full  input  1  UART TX FIFO full
- push  output  1  FIFO write strobe; only asserted when fifo_full=0
- push_data  output  8  byte written with push
- busy  output  1  high from the cycle after an accepted frame_tick until DONE completes
- frame_done  output  1  one-cycle pulse after the checksum byte is pushed

Behaviour:
- Reset: all outputs 0, ram_addr=0, checksum=0, state IDLE. Reset mid-packet aborts immediately; no further pushes and no frame_done.
- All outputs are registered. push and push_data change together. Outputs are asserted in the cycle after the decision, so push=1 requires fifo_full=0 in the cycle before push.
- FSM states: IDLE, HDR0, HDR1, LEN_H, LEN_L, RD_REQ, RD_WAIT, PAY, CKSUM, DONE.
- IDLE: when frame_tick=1, go to HDR0; clear checksum and ram_addr. frame_tick is ignored in every other state and is not queued.
- Emit states (HDR0, HDR1, LEN_H, LEN_L, PAY, CKSUM):
  - If fifo_full=0: push one byte and advance.
  - If fifo_full=1: hold the state with push=0. A stall never drops or duplicates a byte.
- Bytes pushed by state:
  - HDR0 pushes SYNC0.
  - HDR1 pushes SYNC1.
  - LEN_H pushes PAYLOAD_BYTES[15:8].
  - LEN_L pushes PAYLOAD_BYTES[7:0], then goes to RD_REQ.
- RD_REQ: assert ram_re for 1 cycle at ram_addr, then go to RD_WAIT.
- RD_WAIT: capture ram_rdata into a holding register, then go to PAY.
- PAY: push the held byte when fifo_full=0, with checksum ^= byte. Then:
  - if ram_addr == PAYLOAD_BYTES-1, go to CKSUM;
  - otherwise increment ram_addr and go to RD_REQ.
- The held byte is stable across stalls; RAM is not re-read.
- CKSUM: push the accumulated XOR of the payload bytes only (sync and length bytes are excluded), then go to DONE.
- DONE: pulse frame_done for 1 cycle, clear busy, return to IDLE; ram_addr resets to 0.
- ram_addr never exceeds PAYLOAD_BYTES-1, so there is no wrap.
- Packet length is always PAYLOAD_BYTES+5 pushes.
- With no stalls, a packet takes 4 + 3*PAYLOAD_BYTES + 1 + 1 cycles from HDR0 entry to frame_done.
- frame_tick arriving in the same cycle as DONE is ignored.

Test Plan:
- PAYLOAD_BYTES=4, RAM={01,02,04,08}, fifo_full=0, one frame_tick -> pushes AA,55,00,04,01,02,04,08,0F. One frame_done pulse one cycle after the 0F push. busy is low afterwards.
- Same setup, fifo_full high for 5 cycles at a time, in random windows during header, payload and checksum -> identical 9-byte sequence with no duplicates. push is never 1 while fifo_full was 1 the previous cycle.
- frame_tick re-pulsed during the payload phase -> exactly one packet.
- frame_tick re-pulsed after frame_done -> a second identical packet.
- reset asserted after the 6th push -> all outputs 0 next cycle, no frame_done. A new frame_tick then produces a complete packet starting with AA.
- PAYLOAD_BYTES=4800, RAM[i]=i[7:0] -> 4805 pushes. Length bytes 12,C0. Final ram_addr issued is 4799. Checksum equals the XOR of i[7:0] for i=0..4799, which is 00.
